// File: rtl/muldiv_pkg.sv
// Shared constants, state encoding and op-signedness helpers
// for the iterative RV32M multiply/divide sequencer.
package muldiv_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    // rs1 is signed for MUL/MULH/MULHSU/DIV/REM
    function automatic logic op_signed_a(input logic [2:0] f);
        return f[2] ? !f[0] : (f != F3_MULHU);
    endfunction

    // rs2 is signed for MUL/MULH/DIV/REM
    function automatic logic op_signed_b(input logic [2:0] f);
        return f[2] ? !f[0] : !f[1];
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle between the execute stage
// and the multiply/divide sequencer.
interface muldiv_if
    import muldiv_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
);
    logic            start;
    logic            flush;
    logic [2:0]      funct3;
    logic [XLEN-1:0] A;
    logic [XLEN-1:0] B;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, flush, funct3, A, B,
        input  busy, done, result
    );

    modport slave (
        input  start, flush, funct3, A, B,
        output busy, done, result
    );
endinterface

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add for multiply,
// shift/trial-subtract for divide, on a shared 2*XLEN register.
module muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic              is_div,
    input  logic [2*XLEN-1:0] acc,
    input  logic [XLEN-1:0]   opnd,
    output logic [2*XLEN-1:0] acc_next
);
    logic [XLEN:0] sum;
    logic [XLEN:0] part;
    logic [XLEN:0] diff;

    always_comb begin
        sum  = {1'b0, acc[2*XLEN-1:XLEN]}
             + (acc[0] ? {1'b0, opnd} : '0);
        // remainder in upper half, next dividend bit shifted in
        part = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        diff = part - {1'b0, opnd};
        acc_next = '0;
        if (is_div) begin
            if (!diff[XLEN])
                acc_next = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
            else
                acc_next = {part[XLEN-1:0], acc[XLEN-2:0], 1'b0};
        end else begin
            acc_next = {sum, acc[XLEN-1:1]};
        end
    end
endmodule

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide unit beside the execute ALU;
// holds busy while the XLEN-step loop runs.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic    clk,
    input  logic    reset,
    muldiv_if.slave io
);
    localparam int CNT_W = $clog2(XLEN) + 1;

    state_t            state;
    state_t            state_d;
    logic [CNT_W-1:0]  cnt;
    logic [2:0]        op;
    logic              sa;
    logic              sb;
    logic              dz;
    logic              ovf;
    logic [2*XLEN-1:0] acc;
    logic [2*XLEN-1:0] acc_next;
    logic [XLEN-1:0]   opnd;
    logic [XLEN-1:0]   result_q;

    logic              accept;
    logic              sa_in;
    logic              sb_in;
    logic              dz_in;
    logic              ovf_in;
    logic [XLEN-1:0]   a_mag;
    logic [XLEN-1:0]   b_mag;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quot;
    logic [XLEN-1:0]   rem;
    logic [XLEN-1:0]   a_back;
    logic [XLEN-1:0]   fix_val;

    muldiv_step #(.XLEN(XLEN)) u_step (
        .is_div   (op[2]),
        .acc      (acc),
        .opnd     (opnd),
        .acc_next (acc_next)
    );

    always_comb begin
        accept = (state == S_IDLE) && io.start && !io.flush;
        sa_in  = op_signed_a(io.funct3) && io.A[XLEN-1];
        sb_in  = op_signed_b(io.funct3) && io.B[XLEN-1];
        a_mag  = sa_in ? -io.A : io.A;
        b_mag  = sb_in ? -io.B : io.B;
        dz_in  = io.funct3[2] && (io.B == '0);
        ovf_in = io.funct3[2] && !io.funct3[0]
              && (io.A == {1'b1, {(XLEN-1){1'b0}}})
              && (&io.B);
    end

    always_comb begin
        state_d = state;
        unique case (state)
            S_IDLE:
                if (accept)
                    state_d = (dz_in || ovf_in) ? S_FIX : S_CALC;
            S_CALC:
                if (io.flush)
                    state_d = S_IDLE;
                else if (cnt == CNT_W'(XLEN-1))
                    state_d = S_FIX;
            S_FIX:
                state_d = io.flush ? S_IDLE : S_DONE;
            S_DONE:
                state_d = S_IDLE;
            default:
                state_d = S_IDLE;
        endcase
    end

    // sign correction and output selection
    always_comb begin
        prod   = (sa ^ sb) ? -acc : acc;
        quot   = (sa ^ sb) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem    = sa ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        a_back = sa ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        fix_val = '0;
        if (dz)
            fix_val = op[1] ? a_back : '1;
        else if (ovf)
            fix_val = op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
        else if (!op[2])
            fix_val = (op[1:0] == 2'b00) ? prod[XLEN-1:0]
                                         : prod[2*XLEN-1:XLEN];
        else
            fix_val = op[1] ? rem : quot;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            op       <= '0;
            sa       <= 1'b0;
            sb       <= 1'b0;
            dz       <= 1'b0;
            ovf      <= 1'b0;
            acc      <= '0;
            opnd     <= '0;
            result_q <= '0;
        end else begin
            state <= state_d;
            if (accept) begin
                op   <= io.funct3;
                sa   <= sa_in;
                sb   <= sb_in;
                dz   <= dz_in;
                ovf  <= ovf_in;
                acc  <= {{XLEN{1'b0}}, a_mag};
                opnd <= b_mag;
                cnt  <= '0;
            end else if (state == S_CALC) begin
                acc <= acc_next;
                cnt <= cnt + 1'b1;
            end
            if (state == S_FIX && !io.flush)
                result_q <= fix_val;
        end
    end

    assign io.busy   = (state != S_IDLE);
    assign io.done   = (state == S_DONE);
    assign io.result = result_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: vector table, random ops
// against an arithmetic reference, and flush/reset/start corners.
module tb_muldiv_seq;
    import muldiv_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    muldiv_if #(.XLEN(32)) io ();

    muldiv_seq #(.XLEN(32)) dut (
        .clk   (clk),
        .reset (reset),
        .io    (io)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vt [14];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] f3,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
        int          sa;
        int          sb;
        logic [63:0] p;
        sa = signed'(a);
        sb = signed'(b);
        case (f3)
            F3_MUL: begin
                p = longint'(sa) * longint'(sb);
                return p[31:0];
            end
            F3_MULH: begin
                p = longint'(sa) * longint'(sb);
                return p[63:32];
            end
            F3_MULHSU: begin
                p = longint'(sa) * longint'({32'b0, b});
                return p[63:32];
            end
            F3_MULHU: begin
                p = {32'b0, a} * {32'b0, b};
                return p[63:32];
            end
            F3_DIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                    return 32'h8000_0000;
                return 32'(sa / sb);
            end
            F3_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            F3_REM: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                    return 32'h0;
                return 32'(sa % sb);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // start in cycle T; lat = cycle offset at which done is seen
    task automatic run_op(input logic [2:0] f3,
                          input logic [31:0] a,
                          input logic [31:0] b,
                          output logic [31:0] res,
                          output int lat);
        io.funct3 = f3;
        io.A      = a;
        io.B      = b;
        io.start  = 1'b1;
        tick();
        io.start = 1'b0;
        lat = 1;
        while (!io.done && lat < 100) begin
            tick();
            lat++;
        end
        res = io.result;
        tick();
    endtask

    initial begin
        logic [31:0] res;
        logic [31:0] exp;
        int          lat;
        int          ndone;
        int          n;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;

        vt[0]  = '{F3_MUL,    32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34};
        vt[1]  = '{F3_MULH,   32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 34};
        vt[2]  = '{F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF,
                   32'hFFFF_FFFE, 34};
        vt[3]  = '{F3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                   32'hFFFF_FFFF, 34};
        vt[4]  = '{F3_DIV,    32'hFFFF_FFEC, 32'd6, 32'hFFFF_FFFD, 34};
        vt[5]  = '{F3_REM,    32'hFFFF_FFEC, 32'd6, 32'hFFFF_FFFE, 34};
        vt[6]  = '{F3_DIVU,   32'd20, 32'd6, 32'd3, 34};
        vt[7]  = '{F3_REMU,   32'd20, 32'd6, 32'd2, 34};
        vt[8]  = '{F3_DIVU,   32'd5, 32'd0, 32'hFFFF_FFFF, 2};
        vt[9]  = '{F3_REM,    32'd5, 32'd0, 32'd5, 2};
        vt[10] = '{F3_DIV,    32'h8000_0000, 32'hFFFF_FFFF,
                   32'h8000_0000, 2};
        vt[11] = '{F3_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 2};
        vt[12] = '{F3_REM,    32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 2};
        vt[13] = '{F3_MUL,    32'h0001_0000, 32'h0001_0000, 32'h0, 34};

        io.start  = 1'b0;
        io.flush  = 1'b0;
        io.funct3 = 3'b0;
        io.A      = '0;
        io.B      = '0;
        reset     = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_busy", 32'(io.busy), 32'd0);
        chk("rst_done", 32'(io.done), 32'd0);
        chk("rst_result", io.result, 32'd0);

        for (int i = 0; i < 14; i++) begin
            run_op(vt[i].f3, vt[i].a, vt[i].b, res, lat);
            chk($sformatf("vec%0d_res", i), res, vt[i].exp);
            chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(vt[i].lat));
            chk($sformatf("vec%0d_idle", i), 32'(io.busy), 32'd0);
        end

        for (int i = 0; i < 60; i++) begin
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            n  = $urandom_range(0, 9);
            if (n == 0) b = 32'h0;
            if (n == 1) begin
                a = 32'h8000_0000;
                b = 32'hFFFF_FFFF;
            end
            if (n == 2) begin
                a = 32'($urandom_range(0, 255));
                b = 32'($urandom_range(1, 15));
            end
            exp = ref_model(f3, a, b);
            n = (f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000
                 && b == 32'hFFFF_FFFF))) ? 2 : 34;
            run_op(f3, a, b, res, lat);
            chk($sformatf("rnd%0d_f%0d_res", i, f3), res, exp);
            chk($sformatf("rnd%0d_lat", i), 32'(lat), 32'(n));
        end

        // flush mid-CALC: no done, result kept, next op normal
        run_op(F3_DIVU, 32'd100, 32'd7, res, lat);
        chk("pre_flush", res, 32'd14);
        io.funct3 = F3_DIV;
        io.A      = 32'hFFFF_FF9C;
        io.B      = 32'd7;
        io.start  = 1'b1;
        tick();
        io.start = 1'b0;
        repeat (9) tick();
        io.flush = 1'b1;
        tick();
        io.flush = 1'b0;
        chk("flush_busy", 32'(io.busy), 32'd0);
        chk("flush_done", 32'(io.done), 32'd0);
        chk("flush_keep", io.result, 32'd14);
        tick();
        run_op(F3_REM, 32'hFFFF_FF9C, 32'd7, res, lat);
        chk("post_flush_res", res, 32'hFFFF_FFFE);
        chk("post_flush_lat", 32'(lat), 32'd34);

        // reset mid-CALC
        io.funct3 = F3_MUL;
        io.A      = 32'd9;
        io.B      = 32'd9;
        io.start  = 1'b1;
        tick();
        io.start = 1'b0;
        repeat (14) tick();
        reset = 1'b1;
        tick();
        chk("midrst_busy", 32'(io.busy), 32'd0);
        chk("midrst_done", 32'(io.done), 32'd0);
        chk("midrst_result", io.result, 32'd0);
        reset = 1'b0;
        tick();

        // start while busy is ignored
        io.funct3 = F3_MUL;
        io.A      = 32'd3;
        io.B      = 32'd5;
        io.start  = 1'b1;
        tick();
        io.start = 1'b0;
        repeat (4) tick();
        io.A     = 32'd100;
        io.B     = 32'd100;
        io.start = 1'b1;
        tick();
        io.start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 60; i++) begin
            if (io.done) ndone++;
            tick();
        end
        chk("busy_start_ndone", 32'(ndone), 32'd1);
        chk("busy_start_res", io.result, 32'd15);

        // start in the DONE cycle is ignored
        io.funct3 = F3_DIVU;
        io.A      = 32'd9;
        io.B      = 32'd3;
        io.start  = 1'b1;
        tick();
        io.start = 1'b0;
        n = 1;
        while (!io.done && n < 100) begin
            tick();
            n++;
        end
        chk("done_start_lat", 32'(n), 32'd34);
        io.funct3 = F3_MUL;
        io.A      = 32'd2;
        io.B      = 32'd2;
        io.start  = 1'b1;
        tick();
        io.start = 1'b0;
        chk("done_start_busy", 32'(io.busy), 32'd0);
        chk("done_start_res", io.result, 32'd3);

        // flush together with start in IDLE wins
        io.start = 1'b1;
        io.flush = 1'b1;
        tick();
        io.start = 1'b0;
        io.flush = 1'b0;
        chk("idle_flush_busy", 32'(io.busy), 32'd0);
        tick();

        // flush in DONE does not suppress the pulse
        io.funct3 = F3_DIVU;
        io.A      = 32'd5;
        io.B      = 32'd0;
        io.start  = 1'b1;
        tick();
        io.start = 1'b0;
        tick();
        io.flush = 1'b1;
        chk("done_flush_pulse", 32'(io.done), 32'd1);
        tick();
        io.flush = 1'b0;
        chk("done_flush_busy", 32'(io.busy), 32'd0);
        chk("done_flush_res", io.result, 32'hFFFF_FFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
